// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the configurable SPI master:
//     - FSM state encoding (IDLE, SETUP, XFER, HOLD, DONE)
//     - SPI mode constants MODE0..MODE3, encoded as {cpol, cpha}
//     - counter width helper for the SCLK half-period divider
// -----------------------------------------------------------------------------
package spi_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Width of a counter that runs 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        if (div > 1) begin
            return $clog2(div);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   Half-period tick generator for the SPI master. Counts CLK_DIV clk cycles
//   per SCLK half-period while enabled and flags the last cycle of each
//   half-period. While edge_en is high, every tick is also classified as a
//   leading or trailing SCLK edge (alternating, leading first after clr).
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   en       in   count enable
//   clr      in   synchronous clear of counter and edge phase
//   edge_en  in   classify ticks as SCLK edges
//   tick     out  last cycle of the current half-period
//   lead     out  tick that produces a leading SCLK edge
//   trail    out  tick that produces a trailing SCLK edge
// -----------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic edge_en,
    output logic tick,
    output logic lead,
    output logic trail
);

    localparam int               CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;
    logic             tick_s;

    // Half-period counter, wraps at CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Edge phase: 0 means the next edge is a leading one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase_r <= 1'b0;
        end else if (tick_s && edge_en) begin
            phase_r <= ~phase_r;
        end
    end

    // Tick and edge strobe decode.
    always_comb begin
        tick_s = 1'b0;
        lead   = 1'b0;
        trail  = 1'b0;
        if (en && (cnt_r == LAST)) begin
            tick_s = 1'b1;
            lead   = edge_en & ~phase_r;
            trail  = edge_en & phase_r;
        end else begin
            tick_s = 1'b0;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/spi_master_cfg.sv
// -----------------------------------------------------------------------------
// spi_master_cfg
//   Parametrised SPI master: DATA_W-bit words MSB first, SCLK half-period of
//   CLK_DIV clk cycles, run-time CPOL/CPHA, N_SS active-low selects and a
//   start/busy/done handshake. A request with an out-of-range ss_sel is
//   rejected with a one-cycle err pulse.
//
//   Build option: SPI_LOOPBACK_EN -- when defined, the received bit is the
//   master's own MOSI and the MISO pin is ignored (self-test without slave).
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   start    in   transfer request, sampled while idle
//   cpol     in   SCLK idle level, latched on accept
//   cpha     in   0: sample on leading edge, 1: sample on trailing edge
//   ss_sel   in   slave index, latched on accept
//   tx_data  in   word to send, latched on accept
//   rx_data  out  received word, updated with done and then held
//   busy     out  transfer in progress
//   done     out  one-cycle end-of-transfer pulse
//   err      out  one-cycle pulse for a rejected start
//   SCLK     out  SPI clock
//   MOSI     out  master out
//   MISO     in   master in
//   SS       out  active-low slave selects
// -----------------------------------------------------------------------------
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  N_SS    = 1,
    parameter int  CLK_DIV = 4,
    localparam int SEL_W   = $clog2(N_SS) | 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [N_SS-1:0]   SS
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [SEL_W:0]    N_SS_L    = (SEL_W + 1)'(N_SS);

    logic [2:0]        state_r;
    logic              cpol_r;
    logic              cpha_r;
    logic [DATA_W-1:0] tx_sh_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic [DATA_W-1:0] rx_data_r;
    logic [EDGE_W-1:0] edge_cnt_r;
    logic              sclk_r;
    logic              mosi_r;
    logic [N_SS-1:0]   ss_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              sel_ok_s;
    logic              accept_s;
    logic              reject_s;
    logic              cnt_en_s;
    logic              xfer_s;
    logic              tick_s;
    logic              lead_s;
    logic              trail_s;
    logic              capture_s;
    logic              shift_s;
    logic              sample_s;
    logic [N_SS-1:0]   ss_low_s;

    // Start qualification: only an idle master reacts to start.
    always_comb begin
        sel_ok_s = ({1'b0, ss_sel} < N_SS_L);
        ss_low_s = ~(N_SS'(1'b1) << ss_sel);
        if (start && (state_r == ST_IDLE)) begin
            accept_s = sel_ok_s;
            reject_s = ~sel_ok_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Divider runs through SETUP, XFER and HOLD; edges exist only in XFER.
    // With cpha=1 the data edge and the sample edge swap roles.
    always_comb begin
        cnt_en_s = 1'b0;
        xfer_s   = 1'b0;
        case (state_r)
            ST_SETUP: cnt_en_s = 1'b1;
            ST_XFER: begin
                cnt_en_s = 1'b1;
                xfer_s   = 1'b1;
            end
            ST_HOLD:  cnt_en_s = 1'b1;
            default: begin
                cnt_en_s = 1'b0;
                xfer_s   = 1'b0;
            end
        endcase
        if (cpha_r) begin
            shift_s   = lead_s;
            capture_s = trail_s;
        end else begin
            shift_s   = trail_s;
            capture_s = lead_s;
        end
    end

`ifdef SPI_LOOPBACK_EN
    logic unused_miso_s;
    assign unused_miso_s = MISO;

    // Loopback: the received bit is the bit currently driven on MOSI.
    always_comb begin
        sample_s = mosi_r;
    end
`else
    // Normal operation: the received bit comes from the MISO pin.
    always_comb begin
        sample_s = MISO;
    end
`endif

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (cnt_en_s),
        .clr     (accept_s),
        .edge_en (xfer_s),
        .tick    (tick_s),
        .lead    (lead_s),
        .trail   (trail_s)
    );

    // Transfer FSM and all registered pin/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            tx_sh_r    <= {DATA_W{1'b0}};
            rx_sh_r    <= {DATA_W{1'b0}};
            rx_data_r  <= {DATA_W{1'b0}};
            edge_cnt_r <= {EDGE_W{1'b0}};
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            ss_r       <= {N_SS{1'b1}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            // done is raised in the cycle after DONE, together with rx_data.
            done_r <= (state_r == ST_DONE);
            err_r  <= reject_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cpol_r     <= cpol;
                        cpha_r     <= cpha;
                        sclk_r     <= cpol;
                        ss_r       <= ss_low_s;
                        rx_sh_r    <= {DATA_W{1'b0}};
                        edge_cnt_r <= {EDGE_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= ST_SETUP;
                        // cpha=0 presents the MSB before the first edge;
                        // cpha=1 drives it on the first (leading) edge.
                        if (cpha) begin
                            tx_sh_r <= tx_data;
                        end else begin
                            mosi_r  <= tx_data[DATA_W-1];
                            tx_sh_r <= {tx_data[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick_s) begin
                        state_r <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (lead_s || trail_s) begin
                        sclk_r <= ~sclk_r;
                        // Edge counter saturates on the last edge.
                        if (edge_cnt_r == LAST_EDGE) begin
                            state_r <= ST_HOLD;
                        end else begin
                            edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
                        end
                    end
                    if (capture_s) begin
                        rx_sh_r <= {rx_sh_r[DATA_W-2:0], sample_s};
                    end
                    if (shift_s) begin
                        mosi_r  <= tx_sh_r[DATA_W-1];
                        tx_sh_r <= {tx_sh_r[DATA_W-2:0], 1'b0};
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        ss_r    <= {N_SS{1'b1}};
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rx_data_r <= rx_sh_r;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ss_r    <= {N_SS{1'b1}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data = rx_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign SCLK    = sclk_r;
    assign MOSI    = mosi_r;
    assign SS      = ss_r;

endmodule

// File: tb/tb_spi_master_cfg.sv
// -----------------------------------------------------------------------------
// tb_spi_master_cfg
//   Scoreboard bench for spi_master_cfg (DATA_W=8, N_SS=4, CLK_DIV=2).
//   Stimulus pushes the expected response of each accepted transfer; a
//   behavioural SPI slave plus done monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_spi_master_cfg;
    import spi_pkg::*;

    localparam int DW  = 8;
    localparam int NSS = 4;
    localparam int DIV = 2;
    localparam int LAT = (2 * DW + 2) * DIV + 1;
`ifdef SPI_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          cpol;
    logic          cpha;
    logic [2:0]    ss_sel;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          done;
    logic          err;
    logic          SCLK;
    logic          MOSI;
    logic          MISO;
    logic [NSS-1:0] SS;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] mosi;
        logic [3:0] ss;
        int         cyc;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // slave model state
    logic       cur_cpol  = 1'b0;
    logic       cur_cpha  = 1'b0;
    logic [7:0] slv_echo  = 8'h00;
    logic [7:0] slv_tx    = 8'h00;
    logic [7:0] slv_rx    = 8'h00;
    logic [3:0] ss_seen   = 4'hF;
    logic [3:0] prev_ss   = 4'hF;
    logic       prev_sclk = 1'b0;
    int         slv_edges = 0;

    spi_master_cfg #(
        .DATA_W  (DW),
        .N_SS    (NSS),
        .CLK_DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cpol    (cpol),
        .cpha    (cpha),
        .ss_sel  (ss_sel),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .SS      (SS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model and done monitor, both evaluated on the falling clk edge.
    initial begin
        exp_t e;
        logic lead;
        forever begin
            @(negedge clk);
            if ((prev_ss == 4'hF) && (SS != 4'hF)) begin
                slv_tx    = slv_echo;
                slv_rx    = 8'h00;
                slv_edges = 0;
                ss_seen   = SS;
                if (!cur_cpha) begin
                    MISO   = slv_tx[7];
                    slv_tx = {slv_tx[6:0], 1'b0};
                end
            end else if (SS != 4'hF) begin
                ss_seen = ss_seen & SS;
                if (SCLK != prev_sclk) begin
                    slv_edges = slv_edges + 1;
                    lead = (SCLK != cur_cpol);
                    if (lead == !cur_cpha) begin
                        slv_rx = {slv_rx[6:0], MOSI};
                    end else begin
                        MISO   = slv_tx[7];
                        slv_tx = {slv_tx[6:0], 1'b0};
                    end
                end
            end
            prev_ss   = SS;
            prev_sclk = SCLK;

            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL unexpected_done actual=done=1 expected=no_done (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    chk("mosi_word", 32'(slv_rx), 32'(e.mosi));
                    chk("ss_pattern", 32'(ss_seen), 32'(e.ss));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Issue n_words transfers with start held; pushes expectations at accept.
    task automatic issue(input logic [1:0] mode, input logic [2:0] sel, input logic [7:0] tx,
                         input logic [7:0] echo, input int n_words);
        exp_t       e;
        int         a;
        logic [3:0] one;
        one = 4'b0001;
        @(negedge clk);
        cur_cpol = mode[1];
        cur_cpha = mode[0];
        slv_echo = echo;
        cpol     = mode[1];
        cpha     = mode[0];
        ss_sel   = sel;
        tx_data  = tx;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = cyc;
        chk("busy_after_accept", 32'(busy), 32'd1);
        for (int k = 0; k < n_words; k++) begin
            e.rx   = LB ? tx : echo;
            e.mosi = tx;
            e.ss   = ~(one << sel);
            e.cyc  = a + LAT + k * (LAT + 1);
            expq.push_back(e);
        end
        if (n_words > 1) begin
            repeat ((n_words - 1) * (LAT + 1)) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (((expq.size() != 0) || (busy !== 1'b0)) && (n < 400)) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 400) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL timeout_wait_idle actual=pending=%0d expected=0", expq.size());
        end
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        cpol    = 1'b0;
        cpha    = 1'b0;
        ss_sel  = 3'd0;
        tx_data = 8'h00;
        MISO    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss", 32'(SS), 32'hF);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // mode0, MOSI A5, slave echoes 3C, 37-cycle latency
        issue(MODE0, 3'd0, 8'hA5, 8'h3C, 1);
        wait_idle();

        // mode3: SCLK idles high afterwards
        issue(MODE3, 3'd1, 8'h81, 8'h5A, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sclk_idle_mode3", 32'(SCLK), 32'd1);

        // mode1 on last slave, mode2 on slave 2
        issue(MODE1, 3'd3, 8'h5A, 8'hC3, 1);
        wait_idle();
        chk("sclk_idle_mode1", 32'(SCLK), 32'd0);
        issue(MODE2, 3'd2, 8'h0F, 8'hF0, 1);
        wait_idle();

        // out-of-range select -> err pulse, nothing else moves
        @(negedge clk);
        ss_sel = 3'd5;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_ss", 32'(SS), 32'hF);
        chk("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("err_busy_after", 32'(busy), 32'd0);

        // start pulsed mid-transfer is ignored
        issue(MODE0, 3'd0, 8'hC6, 8'h3A, 1);
        repeat (10) @(negedge clk);
        tx_data = 8'hFF;
        ss_sel  = 3'd1;
        start   = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        // reset at the fifth SCLK edge
        issue(MODE0, 3'd1, 8'h33, 8'hCC, 1);
        n = 0;
        while ((slv_edges < 5) && (n < 200)) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        if (n >= 200) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL timeout_edge5 actual=edges=%0d expected=5", slv_edges);
        end
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ss", 32'(SS), 32'hF);
        chk("midrst_sclk", 32'(SCLK), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rx", 32'(rx_data), 32'd0);
        repeat (50) @(negedge clk);
        issue(MODE0, 3'd0, 8'h96, 8'h69, 1);
        wait_idle();

        // back-to-back with start held: one IDLE cycle between transfers
        issue(MODE0, 3'd2, 8'hE7, 8'h18, 2);
        wait_idle();
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
